// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register between CPU stages: valid/ready handshake, flush to a NOP
// bundle, optional 2-entry skid buffer and a saturating stall counter for hazard debug.
module pipe_stage_reg #(
    parameter int                DATA_W    = 32,
    parameter int                SKID      = 0,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              head_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] skid_data;
    logic              in_xfer;
    logic              out_xfer;

    // With the skid buffer, in_ready depends only on registered state so it can be
    // routed upstream without a combinational path from out_ready.
    always_comb begin
        if (SKID != 0)
            in_ready = !RST && !skid_valid;
        else
            in_ready = !RST && (!head_valid || out_ready);
    end

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = head_valid && out_ready;
    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head_data  <= FLUSH_VAL;
            skid_data  <= FLUSH_VAL;
            stall_cnt  <= '0;
        end else begin
            if (head_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);

            if (flush) begin
                head_valid <= 1'b0;
                skid_valid <= 1'b0;
                head_data  <= FLUSH_VAL;
                skid_data  <= FLUSH_VAL;
            end else if (SKID == 0) begin
                if (in_xfer) begin
                    head_valid <= 1'b1;
                    head_data  <= in_data;
                end else if (out_xfer) begin
                    head_valid <= 1'b0;
                end
            end else begin
                if (out_xfer) begin
                    // A full buffer has in_ready low, so promoting skid never races an accept.
                    if (skid_valid) begin
                        head_data  <= skid_data;
                        skid_valid <= 1'b0;
                    end else begin
                        head_valid <= in_xfer;
                        if (in_xfer)
                            head_data <= in_data;
                    end
                end else if (in_xfer) begin
                    if (head_valid) begin
                        skid_valid <= 1'b1;
                        skid_data  <= in_data;
                    end else begin
                        head_valid <= 1'b1;
                        head_data  <= in_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: u0 is the single-entry variant, u1 the skid
// variant with a 4-bit stall counter.
module tb_pipe_stage_reg;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        fl0 = 1'b0, iv0 = 1'b1, or0 = 1'b0;
    logic [31:0] d0  = 32'hDEAD_BEEF;
    logic        ir0, ov0;
    logic [31:0] od0;
    logic [1:0]  occ0;
    logic [15:0] st0;

    logic        fl1 = 1'b0, iv1 = 1'b1, or1 = 1'b0;
    logic [31:0] d1  = 32'hDEAD_BEEF;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [1:0]  occ1;
    logic [3:0]  st1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .FLUSH_VAL(32'h0), .CNT_W(16)) u0 (
        .CLK(CLK), .RST(RST), .flush(fl0), .in_valid(iv0), .in_data(d0), .in_ready(ir0),
        .out_valid(ov0), .out_data(od0), .out_ready(or0), .occupancy(occ0), .stall_cnt(st0));

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .FLUSH_VAL(32'h0), .CNT_W(4)) u1 (
        .CLK(CLK), .RST(RST), .flush(fl1), .in_valid(iv1), .in_data(d1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(or1), .occupancy(occ1), .stall_cnt(st1));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive0(input logic f, input logic v, input logic [31:0] d, input logic r);
        @(negedge CLK);
        fl0 = f; iv0 = v; d0 = d; or0 = r;
    endtask

    task automatic drive1(input logic f, input logic v, input logic [31:0] d, input logic r);
        @(negedge CLK);
        fl1 = f; iv1 = v; d1 = d; or1 = r;
    endtask

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ir;
        logic        ov;
        logic [31:0] od;
        logic        chk_d;
        logic [1:0]  occ;
    } vec_t;

    vec_t vt[13];
    logic exp_ov;
    int   exp_st;

    initial begin
        // skid-mode sequence: stall A/B/C, drain in order, then flush cases
        vt[0]  = '{1'b0, 1'b1, 32'h0A, 1'b0, 1'b1, 1'b1, 32'h0A, 1'b1, 2'd1};
        vt[1]  = '{1'b0, 1'b1, 32'h0B, 1'b0, 1'b1, 1'b1, 32'h0A, 1'b1, 2'd2};
        vt[2]  = '{1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 2'd2};
        vt[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b0, 1'b1, 32'h0B, 1'b1, 2'd1};
        vt[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 2'd1};
        vt[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 2'd0};
        vt[6]  = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 2'd1};
        vt[7]  = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1, 2'd2};
        vt[8]  = '{1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0};
        vt[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0};
        vt[10] = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 2'd1};
        vt[11] = '{1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0};
        vt[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 2'd0};

        // T1: reset with in_valid asserted
        @(posedge CLK); @(posedge CLK); #1;
        check("rst_ov0", ov0, 0);  check("rst_od0", od0, 0);  check("rst_occ0", occ0, 0);
        check("rst_st0", st0, 0);  check("rst_ir0", ir0, 0);
        check("rst_ov1", ov1, 0);  check("rst_od1", od1, 0);  check("rst_occ1", occ1, 0);
        check("rst_st1", st1, 0);  check("rst_ir1", ir1, 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_rel_ir0", ir0, 1); check("rst_rel_ir1", ir1, 1);
        check("rst_rel_ov0", ov0, 0); check("rst_rel_ov1", ov1, 0);
        iv0 = 1'b0; iv1 = 1'b0;
        @(posedge CLK); #1;
        check("post_rst_ov0", ov0, 0); check("post_rst_ov1", ov1, 0);

        // T2: streaming on both variants
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            fl0 = 0; iv0 = 1; d0 = i; or0 = 1;
            fl1 = 0; iv1 = 1; d1 = i; or1 = 1;
            #1;
            check("stream_ir0", ir0, 1); check("stream_ir1", ir1, 1);
            @(posedge CLK); #1;
            check("stream_ov0", ov0, 1); check("stream_od0", od0, i);
            check("stream_ov1", ov1, 1); check("stream_od1", od1, i);
        end
        @(negedge CLK);
        iv0 = 0; iv1 = 0;
        @(posedge CLK); #1;
        check("stream_end_ov0", ov0, 0); check("stream_end_ov1", ov1, 0);
        check("stream_st0", st0, 0);    check("stream_st1", st1, 0);

        // single-entry back-pressure: ready follows out_ready combinationally
        drive0(0, 1, 32'h07, 0);
        @(posedge CLK); #1;
        check("bp0_ov", ov0, 1); check("bp0_od", od0, 32'h07);
        drive0(0, 1, 32'h08, 0);
        #1 check("bp0_ir_stall", ir0, 0);
        @(posedge CLK); #1;
        check("bp0_hold_od", od0, 32'h07); check("bp0_occ", occ0, 1);
        drive0(0, 1, 32'h08, 1);
        #1 check("bp0_ir_drain", ir0, 1);
        @(posedge CLK); #1;
        check("bp0_next_od", od0, 32'h08); check("bp0_next_ov", ov0, 1);
        drive0(0, 0, 32'h00, 1);
        @(posedge CLK); #1;
        check("bp0_empty_ov", ov0, 0); check("bp0_st", st0, 1);

        // T3/T4: table-driven skid sequence with a stall-count model
        exp_ov = 1'b0;
        exp_st = 0;
        for (int i = 0; i < 13; i++) begin
            drive1(vt[i].fl, vt[i].iv, vt[i].d, vt[i].ordy);
            #1 check($sformatf("vec%0d_ir", i), ir1, vt[i].ir);
            if (exp_ov && !vt[i].ordy && exp_st != 15) exp_st++;
            @(posedge CLK); #1;
            check($sformatf("vec%0d_ov", i), ov1, vt[i].ov);
            check($sformatf("vec%0d_occ", i), occ1, vt[i].occ);
            if (vt[i].chk_d) check($sformatf("vec%0d_od", i), od1, vt[i].od);
            check($sformatf("vec%0d_st", i), st1, exp_st);
            exp_ov = vt[i].ov;
        end

        // T5: counter saturation, flush leaves it alone
        drive1(0, 1, 32'h77, 0);
        drive1(0, 0, 32'h00, 0);
        repeat (20) @(posedge CLK);
        #1;
        check("sat_st", st1, 15); check("sat_ov", ov1, 1); check("sat_od", od1, 32'h77);
        drive1(1, 0, 32'h00, 0);
        @(posedge CLK); #1;
        check("sat_flush_ov", ov1, 0); check("sat_flush_st", st1, 15);
        drive1(0, 0, 32'h00, 0);
        @(posedge CLK); #1;
        check("sat_hold_st", st1, 15);

        // T6: asynchronous reset between edges with the skid buffer full
        @(negedge CLK);
        iv0 = 1; d0 = 32'hC1; or0 = 0;
        iv1 = 1; d1 = 32'hC1; or1 = 0;
        @(negedge CLK);
        d1 = 32'hC2;
        @(posedge CLK); #1;
        check("pre_arst_occ1", occ1, 2); check("pre_arst_ov0", ov0, 1);
        #2 RST = 1'b1;
        #1;
        check("arst_ov1", ov1, 0);  check("arst_occ1", occ1, 0);
        check("arst_od1", od1, 0);  check("arst_st1", st1, 0);
        check("arst_ir1", ir1, 0);  check("arst_ov0", ov0, 0);
        check("arst_st0", st0, 0);
        @(negedge CLK);
        RST = 1'b0; iv0 = 0; iv1 = 0;
        #1 check("arst_rel_ir1", ir1, 1);
        @(posedge CLK); #1;
        check("arst_after_ov1", ov1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
